// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant/select bundle between the requesting sources and the
// 8:1 mux arbiter. The arbiter side uses the slave modport.
interface mux8_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] din;
  logic [7:0] gnt;
  logic       s0;
  logic       s1;
  logic       s2;
  logic       valid;
  logic       out;

  modport master (
    output req, din,
    input  gnt, s0, s1, s2, valid, out
  );

  modport slave (
    input  req, din,
    output gnt, s0, s1, s2, valid, out
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for eight requesters driving the select of an 8:1
// bit mux. One owner at a time, grant registered (latency 1), with a hold
// limit that forces rotation when others are waiting. The mux data path is
// combinational from din through the registered select.
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input logic               clk,
  input logic               rst_n,
  mux8_rr_arbiter_if.slave  bus
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     r_state;
  logic [2:0] r_owner;
  logic [2:0] r_ptr;
  logic [7:0] r_cnt;

  state_t     w_state_nxt;
  logic [2:0] w_owner_nxt;
  logic [2:0] w_ptr_nxt;
  logic [7:0] w_cnt_nxt;

  logic [7:0] w_owner_oh;
  logic [7:0] w_search_vec;
  logic [2:0] w_search_base;
  logic [2:0] w_win;
  logic       w_found;

  assign w_owner_oh = 8'(1) << r_owner;

  // State register: owner, last-owner pointer and hold counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= 3'd7;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Winner search: first set bit after the base index, wrapping 7 -> 0.
  // While granted, the current owner is excluded so that both release and
  // forced rotation start from owner+1 and only ever pick someone else.
  always_comb begin
    w_search_vec  = (r_state == GRANT) ? (bus.req & ~w_owner_oh) : bus.req;
    w_search_base = (r_state == GRANT) ? r_owner : r_ptr;
    w_win         = '0;
    w_found       = 1'b0;
    for (int unsigned i = 1; i <= 8; i++) begin
      if (!w_found && w_search_vec[3'(w_search_base + 3'(i))]) begin
        w_win   = 3'(w_search_base + 3'(i));
        w_found = 1'b1;
      end
    end
  end

  // Next-state: grant on any request, hand over on release or hold expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_owner_nxt = w_win;
          w_cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (!bus.req[r_owner]) begin
          w_ptr_nxt = r_owner;
          w_cnt_nxt = '0;
          if (w_found) begin
            w_owner_nxt = w_win;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (r_cnt == HOLD_LAST) begin
          // Saturated: rotate only if someone else is waiting.
          if (w_found) begin
            w_owner_nxt = w_win;
            w_ptr_nxt   = r_owner;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs: one-hot grant, select holds last owner in IDLE, gated data.
  always_comb begin
    bus.valid = (r_state == GRANT);
    bus.gnt   = bus.valid ? w_owner_oh : '0;
    bus.s0    = r_owner[0];
    bus.s1    = r_owner[1];
    bus.s2    = r_owner[2];
    bus.out   = bus.valid & bus.din[r_owner];
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Table-driven bench for mux8_rr_arbiter (MAX_HOLD = 4) with a scoreboard
// queue between stimulus and the sampled response.
module tb_mux8_rr_arbiter;

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] din;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       out;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  vec_t vecs[$];
  vec_t exp_q[$];

  mux8_rr_arbiter_if bus();

  mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic void add(logic r, logic [7:0] q, logic [7:0] d,
                              logic [7:0] g, logic [2:0] s, logic v, logic o);
    vec_t t;
    t.rst_n = r; t.req = q; t.din = d;
    t.gnt = g; t.sel = s; t.valid = v; t.out = o;
    vecs.push_back(t);
  endfunction

  task automatic cmp(string name, int idx, logic [7:0] act, logic [7:0] req_v);
    n_vec++;
    if (act !== req_v) begin
      n_err++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, req_v);
    end
  endtask

  task automatic check(int idx, vec_t e);
    cmp("gnt",   idx, bus.gnt, e.gnt);
    cmp("sel",   idx, {5'd0, bus.s2, bus.s1, bus.s0}, {5'd0, e.sel});
    cmp("valid", idx, {7'd0, bus.valid}, {7'd0, e.valid});
    cmp("out",   idx, {7'd0, bus.out}, {7'd0, e.out});
    cmp("onehot", idx, {7'd0, $onehot0(bus.gnt)}, 8'd1);
  endtask

  task automatic apply(int idx, vec_t v);
    vec_t e;
    rst_n   = v.rst_n;
    bus.req = v.req;
    bus.din = v.din;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    check(idx, e);
  endtask

  initial begin
    logic [7:0] aa;
    vec_t       h;
    n_vec = 0;
    n_err = 0;
    aa = 8'hAA;
    rst_n = 1'b0;
    bus.req = '0;
    bus.din = '0;

    // reset with all requests pending, then requester 0 wins
    add(0, 8'hFF, 8'hFF, 8'h00, 3'd0, 0, 0);
    add(0, 8'hFF, 8'hFF, 8'h00, 3'd0, 0, 0);
    add(1, 8'hFF, 8'hFF, 8'h01, 3'd0, 1, 1);
    add(0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0);
    // single requester 5 held well past the hold limit
    for (int i = 0; i < 21; i++) add(1, 8'h20, 8'h20, 8'h20, 3'd5, 1, 1);
    add(1, 8'h00, 8'h20, 8'h00, 3'd5, 0, 0);
    // wrap-around: owner 6 releases with req 0 and 3 pending -> 0
    add(1, 8'h40, 8'h40, 8'h40, 3'd6, 1, 1);
    add(1, 8'h09, 8'h01, 8'h01, 3'd0, 1, 1);
    add(1, 8'h00, 8'h01, 8'h00, 3'd0, 0, 0);
    // round robin with each owner dropping for one cycle
    add(0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0);
    add(1, 8'hFF, 8'hAA, 8'h01, 3'd0, 1, 0);
    for (int k = 0; k < 8; k++) begin
      int nk;
      nk = (k + 1) % 8;
      add(1, ~(8'(1) << k), 8'hAA, 8'(1) << nk, 3'(nk), 1, aa[nk]);
    end
    // forced rotation at MAX_HOLD = 4
    add(0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 8'h81, 8'h80, 8'h01, 3'd0, 1, 0);
    for (int i = 0; i < 4; i++) add(1, 8'h81, 8'h80, 8'h80, 3'd7, 1, 1);
    for (int i = 0; i < 4; i++) add(1, 8'h81, 8'h80, 8'h01, 3'd0, 1, 0);
    // mid-grant reset, pointer back to 7
    add(0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0);
    add(1, 8'h08, 8'h08, 8'h08, 3'd3, 1, 1);
    add(0, 8'h08, 8'h08, 8'h00, 3'd0, 0, 0);
    add(1, 8'h18, 8'h08, 8'h08, 3'd3, 1, 1);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // owner 3 releases as 5 holds its request: immediate handover
    h.rst_n = 1; h.req = 8'h20; h.din = 8'h20;
    h.gnt = 8'h20; h.sel = 3'd5; h.valid = 1; h.out = 1;
    apply(1000, h);
    // data path is combinational from din
    bus.din = 8'h00;
    #1 cmp("out_comb0", 1001, {7'd0, bus.out}, 8'd0);
    bus.din = 8'hDF;
    #1 cmp("out_comb1", 1002, {7'd0, bus.out}, 8'd0);
    bus.din = 8'h20;
    #1 cmp("out_comb2", 1003, {7'd0, bus.out}, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter and select sequencer for the 8-to-1 bit multiplexer datapath.
- Eight requesters compete for the shared output. The block grants one requester at a time and drives the 3-bit select {s2,s1,s0}.
- It forwards the granted input to out and enforces a maximum hold time so that no requester starves the others.
- It sits between the requesting sources and the 8:1 mux; the mux function is folded in as a gated combinational path.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one requester keeps the grant while others wait. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- req  input  8  request vector; bit k = requester k (maps to mux input ik).
- din  input  8  data inputs; din[k] is mux input ik.
- gnt  output  8  one-hot grant; all-zero when idle.
- s0  output  1  select bit 0 (LSB) of the granted index.
- s1  output  1  select bit 1 of the granted index.
- s2  output  1  select bit 2 (MSB) of the granted index.
- valid  output  1  high while a grant is active.
- out  output  1  din[{s2,s1,s0}] when valid = 1, else 1'b0.

Behaviour:
- Reset (rst_n = 0 at a rising edge):
  - state = IDLE, gnt = 8'h00, {s2,s1,s0} = 3'b000, valid = 0.
  - Last-owner pointer = 3'd7, so requester 0 has first priority after reset.
  - Hold counter = 0.
  - out = 0 follows from valid = 0.
- Reset mid-grant drops the grant at that edge; there is no completion of the current hold.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0 at an edge, go to GRANT.
  - Winner = first set bit searching ptr+1, ptr+2, ... modulo 8 (wraps 7 -> 0).
  - Grant, select and valid become visible one cycle after req is sampled (registered, latency 1).
- GRANT (owner k):
  - Counter increments each cycle and saturates at MAX_HOLD-1. Counter width is 8 bits.
  - Owner drops req[k], another request pending: hand over at the same edge to the next round-robin winner starting from k+1. No idle bubble; counter reloads to 0; ptr = k.
  - Owner drops req[k], no other request pending: go to IDLE; gnt = 0, valid = 0; ptr = k.
  - Counter == MAX_HOLD-1, req[k] still high, another request pending: forced rotation to the next winner from k+1. The counter is reset and ptr = k. Requester k re-enters the round-robin queue.
  - Counter == MAX_HOLD-1, no other request pending: keep granting k; the counter stays saturated.
  - MAX_HOLD = 1: rotate every cycle whenever other requests exist.
- Invariants:
  - gnt is always one-hot or zero.
  - {s2,s1,s0} always equals the index of the set gnt bit and holds its last value in IDLE.
  - valid == |gnt.
- out path: purely combinational from din and the registered select/valid; there is no register on data.
- Requests are level-sensitive. A requester deasserting while not granted simply leaves the queue.
- Simultaneous owner release and new requests at the same edge are resolved in one edge, per the rules above.
- Requests arriving during an active grant are queued, not lost, as long as they are held high.

Test Plan:
- Reset: rst_n = 0 for 2 cycles with req = 8'hFF -> gnt = 8'h00, valid = 0, out = 0, select = 000. Release reset -> next edge gnt = 8'h01, select = 000.
- Single requester: req = 8'h20, din = 8'h20 -> after 1 cycle gnt = 8'h20, {s2,s1,s0} = 101, out = 1. Set din = 8'h00 -> out = 0 same cycle. Hold req for 20 cycles (MAX_HOLD = 8) -> grant never drops.
- Round-robin fairness: req = 8'hFF; each owner drops its req for one cycle upon grant, then reasserts. -> Grants in order 0,1,2,...,7,0 with no idle cycles between them.
- Forced rotation: MAX_HOLD = 4; req = 8'h81 held constant -> gnt alternates 8'h01 for 4 cycles, then 8'h80 for 4 cycles, and so on.
- Wrap-around: owner 6 releases while req = 8'h09 -> next gnt = 8'h01 (search 7 -> 0), not 8'h08.
- Mid-operation reset: reset during grant to requester 3 -> gnt = 0 next edge. After release with req = 8'h18 -> gnt = 8'h08 (pointer reset to 7).
